uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16: sample ticks per bit; even, at least 4.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: depth of the rxd synchronizer, at least 2.
REQ-004 Port clk, input, width 1: the single clock.
REQ-005 Port rst, input, width 1: asynchronous, active-high reset.
REQ-006 Port baud_div, input, width 16: the sample tick period is baud_div+1 clk cycles.
REQ-007 Port rx_enable, input, width 1: receiver enable.
REQ-008 Port rxd, input, width 1: asynchronous serial input; idle level is 1.
REQ-009 Port rx_data, output, width DATA_BITS: received byte.
REQ-010 Port rx_valid, output, width 1: rx_data holds a byte not yet accepted.
REQ-011 Port rx_ready, input, width 1: downstream accepts rx_data when rx_valid is also high.
REQ-012 Port frame_err, output, width 1: one-cycle pulse when the stop bit samples 0.
REQ-013 Port overrun_err, output, width 1: one-cycle pulse when a completed byte is dropped.
REQ-014 Port rx_busy, output, width 1: the FSM is outside IDLE.

Function
REQ-015 rxd SHALL pass through SYNC_STAGES flops; the FSM SHALL see only the synchronized value.
REQ-016 The tick counter SHALL count 0..baud_div and pulse tick at terminal count.
REQ-017 The tick counter SHALL clear to 0 in IDLE and on start detection, so sampling aligns to the start edge.
REQ-018 With baud_div=0, tick SHALL be high every cycle.
REQ-019 The FSM SHALL have exactly the states IDLE, START, DATA, STOP and BRK_WAIT.
REQ-020 IDLE SHALL go to START when rx_enable=1 and synchronized rxd=0, clearing the sample counter.
REQ-021 START SHALL, at tick count OVERSAMPLE/2, go to DATA if rxd=0 and otherwise treat it as a glitch and go to IDLE with no output.
REQ-022 DATA SHALL sample rxd every OVERSAMPLE ticks into a shift register, LSB first, and go to STOP after DATA_BITS samples.
REQ-023 STOP SHALL sample after OVERSAMPLE ticks: on 1, deliver the byte and go to IDLE; on 0, pulse frame_err, discard the byte and go to BRK_WAIT.
REQ-024 BRK_WAIT SHALL go to IDLE only once synchronized rxd=1, so a held break does not retrigger.
REQ-025 Delivery SHALL load rx_data and set rx_valid on the clock edge after the stop sample.
REQ-026 rx_data SHALL remain stable while rx_valid=1.
REQ-027 rx_valid SHALL clear on the cycle after rx_valid && rx_ready.
REQ-028 If a delivery occurs while rx_valid=1 and rx_ready=0, the new byte SHALL be dropped, rx_data retained and overrun_err pulsed.
REQ-029 If a delivery occurs in the same cycle as rx_valid && rx_ready, the new byte SHALL be loaded, rx_valid SHALL stay 1 and no overrun SHALL be flagged.
REQ-030 rx_enable=0 SHALL force the FSM to IDLE on the next edge and abort any frame in progress, with no output or error.
REQ-031 rx_enable=0 SHALL leave rx_valid and rx_data unaffected.
REQ-032 A change of baud_div mid-frame SHALL give undefined data, but the FSM SHALL return to IDLE.

Reset
REQ-033 On rst, the FSM SHALL enter IDLE and the tick and sample counters SHALL clear to 0.
REQ-034 On rst, synchronizer flops SHALL set to 1, rx_data to 0, and rx_valid, frame_err, overrun_err and rx_busy to 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial byte.
REQ-036 After reset deasserts, a start bit SHALL be recognized only from a fresh falling edge.

Structure
REQ-037 The state enum uart_rx_state_t and default constants for OVERSAMPLE and DATA_BITS SHALL live in the shared package uart_pkg.
REQ-038 The tick generator SHALL be the single sub-module uart_baud_tick, with ports clk, rst, clear, baud_div and tick.

Verification
REQ-039 baud_div=3, 0xA5 sent with 64-clk bits -> rx_valid=1, rx_data=0xA5, frame_err=0, within SYNC_STAGES+9.5*64+4 cycles of the start edge.
REQ-040 A 20-clk low glitch on rxd at baud_div=3 -> FSM returns to IDLE and rx_valid stays 0.
REQ-041 0x3C with stop bit 0, then rxd held low 500 cycles -> one frame_err pulse, no rx_valid, FSM stays in BRK_WAIT until rxd=1, then a following 0x55 is received.
REQ-042 rx_ready=0, 0x11 then 0x22 sent -> rx_data=0x11 held, one overrun_err pulse.
REQ-043 rx_ready pulsed in the stop-sample delivery cycle of 0x22 -> rx_data=0x22, no overrun.
REQ-044 rst or rx_enable=0 asserted mid-DATA of 0xFF -> no output or error, and the next 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver FSM states; BRK_WAIT parks the FSM while a line break is held low.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } uart_rx_state_t;

    // Default frame geometry.
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_SYNC_STAGES = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..baud_div counter that pulses tick at terminal count.
// Latency: tick is decoded from the counter register, so it follows clear by baud_div+1 cycles.
// Backpressure: none; clear holds the counter at 0 so sampling can align to a start edge.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] baud_div,
    output logic        tick
);

    logic [15:0] cnt;

    // Terminal count; ">=" also recovers if baud_div shrinks below the current count.
    assign tick = (cnt >= baud_div);

    // Count 0..baud_div and wrap; clear forces the phase back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (clear || tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rxd, oversamples each bit at mid-point, delivers bytes on a valid/ready port.
// Latency: rx_valid rises one clk after the stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: single holding register; a byte completing while rx_valid && !rx_ready is dropped with overrun_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          baud_div,
    input  logic                 rx_enable,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int SCNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BCNT_W = $clog2(DATA_BITS + 1);

    // Tick counts at which START checks mid-bit and DATA/STOP take their sample.
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BITS_LAST = BCNT_W'(DATA_BITS - 1);

    uart_rx_state_t        state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic [SYNC_STAGES-1:0] sync_live;
    logic                   rxd_s;
    logic                   sync_ok;
    logic                   armed;
    logic                   tick;
    logic                   tick_clear;
    logic [SCNT_W-1:0]      scnt;
    logic [BCNT_W-1:0]      bcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   deliver;

    assign rxd_s      = sync_ff[SYNC_STAGES-1];
    assign sync_ok    = sync_live[SYNC_STAGES-1];
    // Hold the tick phase at 0 while idle so the first tick lands baud_div+1 clks after start detection.
    assign tick_clear = (state == IDLE);

    // rxd metastability chain; sync_live marks when the chain holds real line samples rather than reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff   <= '1;
            sync_live <= '0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], rxd};
            sync_live <= {sync_live[SYNC_STAGES-2:0], 1'b1};
        end
    end

    uart_baud_tick u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (tick_clear),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // Frame FSM: start qualification, LSB-first data shift, stop check, break hold-off.
    // armed requires a real high level seen in IDLE, so only a fresh falling edge starts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_enable) begin
                state   <= IDLE;
                scnt    <= '0;
                bcnt    <= '0;
                rx_busy <= 1'b0;
                if (state == IDLE && sync_ok && rxd_s) begin
                    armed <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        scnt <= '0;
                        bcnt <= '0;
                        if (armed && !rxd_s) begin
                            state   <= START;
                            armed   <= 1'b0;
                            rx_busy <= 1'b1;
                        end else if (sync_ok && rxd_s) begin
                            armed <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (scnt == HALF_LAST) begin
                                scnt <= '0;
                                if (!rxd_s) begin
                                    state <= DATA;
                                end else begin
                                    state   <= IDLE;
                                    rx_busy <= 1'b0;
                                end
                            end else begin
                                scnt <= scnt + SCNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (scnt == FULL_LAST) begin
                                scnt  <= '0;
                                shreg <= (shreg >> 1) | (DATA_BITS'(rxd_s) << (DATA_BITS - 1));
                                if (bcnt == BITS_LAST) begin
                                    bcnt  <= '0;
                                    state <= STOP;
                                end else begin
                                    bcnt <= bcnt + BCNT_W'(1);
                                end
                            end else begin
                                scnt <= scnt + SCNT_W'(1);
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (scnt == FULL_LAST) begin
                                scnt <= '0;
                                if (rxd_s) begin
                                    deliver <= 1'b1;
                                    state   <= IDLE;
                                    rx_busy <= 1'b0;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= BRK_WAIT;
                                end
                            end else begin
                                scnt <= scnt + SCNT_W'(1);
                            end
                        end
                    end
                    BRK_WAIT: begin
                        if (rxd_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register: load on delivery if empty or being drained this cycle, otherwise drop and flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
